// File: rtl/cdb_result_buffer.sv
// Per-functional-unit result FIFO that feeds the CDB controller. It holds
// completed results in push order and offers the oldest as the bus request.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] value;
  } cdb_packet_s;
endpackage

module cdb_result_buffer
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  cdb_packet_s      fu_result_i,
  output logic             fu_ready_o,
  output cdb_packet_s      cdb_request_o,
  input  logic             grant_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full, empty, push, pop;
  cdb_packet_s      entry_vec [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready and request derive only from registered state, so the arbiter's
  // grant can never loop back combinationally into this block.
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign fu_ready_o = !full;
  assign count_o    = count_reg;

  assign push = fu_result_i.valid && !full && !flush_i;
  assign pop  = grant_i && !empty && !flush_i;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = ptr_inc(tail_reg);
      if (pop)  head_next = ptr_inc(head_reg);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage is left unreset; it is only observed while non-empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      cdb_packet_s entry_reg;
      always_ff @(posedge clk_i) begin
        if (push && (tail_reg == PTR_W'(gi))) entry_reg <= fu_result_i;
      end
      assign entry_vec[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    cdb_request_o = '0;
    if (!empty) begin
      cdb_request_o       = entry_vec[head_reg];
      cdb_request_o.valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Directed bench for cdb_result_buffer: driver records accepted pushes in a
// scoreboard queue, a monitor checks each granted head against it.
module tb_cdb_result_buffer;
  import cdb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             grant = 1'b0;
  cdb_packet_s      fu_result = '0;
  logic             fu_ready;
  cdb_packet_s      cdb_request;
  logic [CNT_W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  cdb_packet_s sb[$];

  always #5 clk = ~clk;

  cdb_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .flush_i       (flush),
    .fu_result_i   (fu_result),
    .fu_ready_o    (fu_ready),
    .cdb_request_o (cdb_request),
    .grant_i       (grant),
    .count_o       (count)
  );

  function automatic cdb_packet_s mk(input logic [31:0] v);
    cdb_packet_s p;
    p.valid = 1'b1;
    p.tag   = v[5:0];
    p.value = v;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic g,
                      input logic f, input logic r);
    cdb_packet_s p;
    logic accept;
    p = mk(d);
    p.valid = v;
    fu_result = p;
    grant = g;
    flush = f;
    reset = r;
    accept = v && !f && !r && (sb.size() < DEPTH);
    @(posedge clk);
    if (r || f) sb.delete();
    else if (accept) sb.push_back(p);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every effective grant must retire the oldest recorded push.
  always @(negedge clk) begin
    cdb_packet_s e;
    if (!reset && !flush && grant && (sb.size() != 0 || cdb_request.valid)) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL grant_pop: got valid head %0h, required empty", cdb_request.value);
      end else begin
        e = sb.pop_front();
        if (!cdb_request.valid || cdb_request.tag !== e.tag || cdb_request.value !== e.value) begin
          n_fail++;
          $display("[TB] FAIL grant_pop: got v=%0b tag=%0h val=%0h, required v=1 tag=%0h val=%0h",
                   cdb_request.valid, cdb_request.tag, cdb_request.value, e.tag, e.value);
        end else begin
          $display("[TB] grant tag=%0h value=%0h ok", e.tag, e.value);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    // Reset then idle
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(fu_ready), 64'd1);
    chk("reset_request", 64'(cdb_request), 64'd0);
    idle();
    chk("idle_valid", 64'(cdb_request.valid), 64'd0);

    // Single result
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    chk("single_count", 64'(count), 64'd1);
    chk("single_head", 64'(cdb_request.value), 64'hA);
    chk("single_valid", 64'(cdb_request.valid), 64'd1);
    idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("single_drain_count", 64'(count), 64'd0);
    chk("single_drain_valid", 64'(cdb_request.valid), 64'd0);

    // Fill and backpressure
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b0, 1'b0, 1'b0);
    chk("fill3_ready", 64'(fu_ready), 64'd1);
    step(1'b1, 32'hD4, 1'b0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(fu_ready), 64'd0);
    step(1'b1, 32'hE5, 1'b0, 1'b0, 1'b0);
    chk("full_reject_count", 64'(count), 64'd4);
    chk("full_head", 64'(cdb_request.value), 64'hA1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("unfull_count", 64'(count), 64'd3);
    chk("unfull_ready", 64'(fu_ready), 64'd1);
    chk("unfull_head", 64'(cdb_request.value), 64'hB2);
    step(1'b1, 32'hE5, 1'b0, 1'b0, 1'b0);
    chk("e_capture_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fill_drained", 64'(count), 64'd0);

    // Simultaneous push and pop across pointer wrap
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h102 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("pushpop_count", 64'(count), 64'd2);
    end
    chk("pushpop_head", 64'(cdb_request.value), 64'h106);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pushpop_drained", 64'(count), 64'd0);

    // Flush mid-operation with concurrent push and grant
    step(1'b1, 32'h201, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h203, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", 64'(count), 64'd3);
    step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(cdb_request.valid), 64'd0);
    chk("flush_ready", 64'(fu_ready), 64'd1);
    step(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
    chk("postflush_count", 64'(count), 64'd1);
    chk("postflush_head", 64'(cdb_request.value), 64'hF0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Spurious grant while empty
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("spurious_count", 64'(count), 64'd0);
    chk("spurious_valid", 64'(cdb_request.valid), 64'd0);
    chk("spurious_ready", 64'(fu_ready), 64'd1);

    // Reset mid-stream
    step(1'b1, 32'h301, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h302, 1'b0, 1'b0, 1'b0);
    chk("prereset_count", 64'(count), 64'd2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_ready", 64'(fu_ready), 64'd1);
    chk("midreset_request", 64'(cdb_request), 64'd0);
    step(1'b1, 32'h3A, 1'b0, 1'b0, 1'b0);
    chk("postreset_head", 64'(cdb_request.value), 64'h3A);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
